// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU command encodings, default widths and
// the legal-command screen used by the decoder, ALU and ID/EXE register.
package mips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CMD_W      = 4;

    localparam logic [CMD_W-1:0] CMD_ADD = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AND = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_OR  = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_NOR = 4'b0110;
    localparam logic [CMD_W-1:0] CMD_XOR = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_SLL = 4'b1000;
    localparam logic [CMD_W-1:0] CMD_SRA = 4'b1001;
    localparam logic [CMD_W-1:0] CMD_SRL = 4'b1010;

    // True for the nine commands the ALU implements.
    function automatic logic is_legal_cmd(input logic [CMD_W-1:0] cmd);
        case (cmd)
            CMD_ADD, CMD_SUB, CMD_AND, CMD_OR, CMD_NOR,
            CMD_XOR, CMD_SLL, CMD_SRA, CMD_SRL: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic W-bit pipeline register.
// Ports: clk, rst_n (sync, active low), clr (load zero, beats en),
//        en (load d), d (next value), q (registered value).
module pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n)    q <= '0;
        else if (clr)  q <= '0;
        else if (en)   q <= d;
    end

endmodule

// File: rtl/id_exe_reg.sv
// ID->EXE pipeline register of the 5-stage MIPS core.
// Captures operands, ALU command and control bits at the end of ID and holds
// them for one EXE cycle. Supports stall (freeze), bubble (flush) and
// screening of unsupported commands (ex_illegal).
// Ports: clk, rst_n (sync, active low), freeze, flush, id_* (ID stage slot),
//        ex_* (registered copies), ex_illegal, perf_bubbles, perf_stalls.
// Macro ID_EXE_PERF_EN: when defined, perf_bubbles/perf_stalls count flush
// and freeze cycles (saturating); otherwise both are tied to zero.
module id_exe_reg #(
    parameter int unsigned DATA_W     = mips_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int unsigned CMD_W      = mips_pkg::CMD_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_val1,
    input  logic [DATA_W-1:0]     id_val2,
    input  logic [DATA_W-1:0]     id_st_val,
    input  logic [CMD_W-1:0]      id_exe_cmd,
    input  logic                  id_mem_r_en,
    input  logic                  id_mem_w_en,
    input  logic                  id_wb_en,
    input  logic [REG_ADDR_W-1:0] id_dest,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_val1,
    output logic [DATA_W-1:0]     ex_val2,
    output logic [DATA_W-1:0]     ex_st_val,
    output logic [CMD_W-1:0]      ex_exe_cmd,
    output logic                  ex_mem_r_en,
    output logic                  ex_mem_w_en,
    output logic                  ex_wb_en,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  ex_illegal,
    output logic [31:0]           perf_bubbles,
    output logic [31:0]           perf_stalls
);

    import mips_pkg::is_legal_cmd;
    import mips_pkg::CMD_ADD;

    localparam int unsigned DATA_GRP_W = 4 * DATA_W + REG_ADDR_W;
    localparam int unsigned CTRL_GRP_W = CMD_W + 5;

    logic                  illegal;
    logic                  issue_ok;
    logic [DATA_GRP_W-1:0] data_d;
    logic [CTRL_GRP_W-1:0] ctrl_d;

    // Screen the command; a simultaneous load+store is also rejected.
    always_comb begin
        illegal  = id_valid & (~is_legal_cmd(4'(id_exe_cmd)) | (id_mem_r_en & id_mem_w_en));
        issue_ok = id_valid & ~illegal;
        data_d   = {id_pc, id_val1, id_val2, id_st_val, id_dest};
        ctrl_d   = {id_valid,
                    illegal ? CMD_W'(CMD_ADD) : id_exe_cmd,
                    id_mem_r_en & issue_ok,
                    id_mem_w_en & issue_ok,
                    id_wb_en    & issue_ok,
                    illegal};
    end

    pipe_reg #(.W(DATA_GRP_W)) u_data (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (~freeze),
        .d     (data_d),
        .q     ({ex_pc, ex_val1, ex_val2, ex_st_val, ex_dest})
    );

    pipe_reg #(.W(CTRL_GRP_W)) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (~freeze),
        .d     (ctrl_d),
        .q     ({ex_valid, ex_exe_cmd, ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_illegal})
    );

`ifdef ID_EXE_PERF_EN
    // Saturating flush / stall cycle counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_bubbles <= '0;
            perf_stalls  <= '0;
        end else begin
            if (flush && (perf_bubbles != 32'hFFFF_FFFF))
                perf_bubbles <= perf_bubbles + 32'd1;
            if (freeze && !flush && (perf_stalls != 32'hFFFF_FFFF))
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`else
    assign perf_bubbles = '0;
    assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
module tb_id_exe_reg;

    logic        clk = 1'b0;
    logic        rst_n, freeze, flush, id_valid;
    logic [31:0] id_pc, id_val1, id_val2, id_st_val;
    logic [3:0]  id_exe_cmd;
    logic        id_mem_r_en, id_mem_w_en, id_wb_en;
    logic [4:0]  id_dest;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_val1, ex_val2, ex_st_val;
    logic [3:0]  ex_exe_cmd;
    logic        ex_mem_r_en, ex_mem_w_en, ex_wb_en;
    logic [4:0]  ex_dest;
    logic        ex_illegal;
    logic [31:0] perf_bubbles, perf_stalls;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_exe_reg dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_val1(id_val1), .id_val2(id_val2),
        .id_st_val(id_st_val), .id_exe_cmd(id_exe_cmd), .id_mem_r_en(id_mem_r_en),
        .id_mem_w_en(id_mem_w_en), .id_wb_en(id_wb_en), .id_dest(id_dest),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_val1(ex_val1), .ex_val2(ex_val2),
        .ex_st_val(ex_st_val), .ex_exe_cmd(ex_exe_cmd), .ex_mem_r_en(ex_mem_r_en),
        .ex_mem_w_en(ex_mem_w_en), .ex_wb_en(ex_wb_en), .ex_dest(ex_dest),
        .ex_illegal(ex_illegal), .perf_bubbles(perf_bubbles), .perf_stalls(perf_stalls)
    );

    typedef struct packed {
        logic        rst_n, frz, fl, v;
        logic [31:0] pc, a, b, st;
        logic [3:0]  cmd;
        logic        r, w, wb;
        logic [4:0]  dst;
        logic        ev;
        logic [31:0] epc, ea, eb, est;
        logic [3:0]  ecmd;
        logic        er, ew, ewb;
        logic [4:0]  edst;
        logic        eill;
        logic [31:0] estl, ebub;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rst_n = x.rst_n; freeze = x.frz; flush = x.fl; id_valid = x.v;
        id_pc = x.pc; id_val1 = x.a; id_val2 = x.b; id_st_val = x.st;
        id_exe_cmd = x.cmd; id_mem_r_en = x.r; id_mem_w_en = x.w;
        id_wb_en = x.wb; id_dest = x.dst;
    endtask

    task automatic check(input int idx, input vec_t x);
        logic [31:0] es, eb;
`ifdef ID_EXE_PERF_EN
        es = x.estl; eb = x.ebub;
`else
        es = 32'd0;  eb = 32'd0;
`endif
        chk("ex_valid",    idx, 32'(ex_valid),    32'(x.ev));
        chk("ex_pc",       idx, ex_pc,            x.epc);
        chk("ex_val1",     idx, ex_val1,          x.ea);
        chk("ex_val2",     idx, ex_val2,          x.eb);
        chk("ex_st_val",   idx, ex_st_val,        x.est);
        chk("ex_exe_cmd",  idx, 32'(ex_exe_cmd),  32'(x.ecmd));
        chk("ex_mem_r_en", idx, 32'(ex_mem_r_en), 32'(x.er));
        chk("ex_mem_w_en", idx, 32'(ex_mem_w_en), 32'(x.ew));
        chk("ex_wb_en",    idx, 32'(ex_wb_en),    32'(x.ewb));
        chk("ex_dest",     idx, 32'(ex_dest),     32'(x.edst));
        chk("ex_illegal",  idx, 32'(ex_illegal),  32'(x.eill));
        chk("perf_stalls", idx, perf_stalls,      es);
        chk("perf_bubbles",idx, perf_bubbles,     eb);
    endtask

    initial begin
        //           rst frz fl v  pc            val1          val2          st            cmd   r  w  wb dst    | ev epc           ea            eb            est           ecmd  er ew ewb edst  ill stl    bub
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b1, 32'hAAAA_5555, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 4'h2, 1'b1,1'b0,1'b1, 5'd17,
                     1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0,1'b0,1'b0, 5'd0, 1'b0, 32'd0, 32'd0};
        vecs[1]  = '{1'b0,1'b1,1'b1,1'b1, 32'h5555_AAAA, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'hB, 1'b1,1'b1,1'b1, 5'd31,
                     1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0,1'b0,1'b0, 5'd0, 1'b0, 32'd0, 32'd0};
        // load SUB 5,3 -> r8
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b1, 32'h0000_0104, 32'h0000_0005, 32'h0000_0003, 32'h0000_0011, 4'h2, 1'b0,1'b0,1'b1, 5'd8,
                     1'b1, 32'h104, 32'h5, 32'h3, 32'h11, 4'h2, 1'b0,1'b0,1'b1, 5'd8, 1'b0, 32'd0, 32'd0};
        // three freeze cycles with changing id_*
        vecs[3]  = '{1'b1,1'b1,1'b0,1'b1, 32'h0000_0200, 32'h0000_0007, 32'h0000_0009, 32'h0000_0033, 4'h4, 1'b1,1'b0,1'b1, 5'd2,
                     1'b1, 32'h104, 32'h5, 32'h3, 32'h11, 4'h2, 1'b0,1'b0,1'b1, 5'd8, 1'b0, 32'd1, 32'd0};
        vecs[4]  = '{1'b1,1'b1,1'b0,1'b0, 32'h0000_0204, 32'h0000_0008, 32'h0000_000A, 32'h0000_0044, 4'hC, 1'b0,1'b1,1'b0, 5'd3,
                     1'b1, 32'h104, 32'h5, 32'h3, 32'h11, 4'h2, 1'b0,1'b0,1'b1, 5'd8, 1'b0, 32'd2, 32'd0};
        vecs[5]  = '{1'b1,1'b1,1'b0,1'b1, 32'h0000_0208, 32'h0000_0009, 32'h0000_000B, 32'h0000_0055, 4'h7, 1'b1,1'b1,1'b1, 5'd4,
                     1'b1, 32'h104, 32'h5, 32'h3, 32'h11, 4'h2, 1'b0,1'b0,1'b1, 5'd8, 1'b0, 32'd3, 32'd0};
        // flush and freeze together -> bubble
        vecs[6]  = '{1'b1,1'b1,1'b1,1'b1, 32'h0000_020C, 32'h0000_000A, 32'h0000_000C, 32'h0000_0066, 4'h5, 1'b0,1'b0,1'b1, 5'd5,
                     1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0,1'b0,1'b0, 5'd0, 1'b0, 32'd3, 32'd1};
        // cmd 1011 with wb and store -> screened
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b1, 32'h0000_0108, 32'h0000_0009, 32'h0000_0001, 32'h0000_0022, 4'hB, 1'b0,1'b1,1'b1, 5'd3,
                     1'b1, 32'h108, 32'h9, 32'h1, 32'h22, 4'h0, 1'b0,1'b0,1'b0, 5'd3, 1'b1, 32'd3, 32'd1};
        // legal XOR load clears ex_illegal
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b1, 32'h0000_010C, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'h7, 1'b1,1'b0,1'b1, 5'd31,
                     1'b1, 32'h10C, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'h7, 1'b1,1'b0,1'b1, 5'd31, 1'b0, 32'd3, 32'd1};
        // id_valid=0: controls cleared, data latched
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b0, 32'h0000_0110, 32'h0000_0012, 32'h0000_0034, 32'h0000_0056, 4'h0, 1'b1,1'b1,1'b1, 5'd4,
                     1'b0, 32'h110, 32'h12, 32'h34, 32'h56, 4'h0, 1'b0,1'b0,1'b0, 5'd4, 1'b0, 32'd3, 32'd1};
        // load and store both set -> illegal
        vecs[10] = '{1'b1,1'b0,1'b0,1'b1, 32'h0000_0114, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'h0, 1'b1,1'b1,1'b0, 5'd2,
                     1'b1, 32'h114, 32'h1, 32'h2, 32'h3, 4'h0, 1'b0,1'b0,1'b0, 5'd2, 1'b1, 32'd3, 32'd1};
        // cmd 0001 -> illegal
        vecs[11] = '{1'b1,1'b0,1'b0,1'b1, 32'h0000_0118, 32'h0000_0004, 32'h0000_0005, 32'h0000_0006, 4'h1, 1'b0,1'b0,1'b1, 5'd7,
                     1'b1, 32'h118, 32'h4, 32'h5, 32'h6, 4'h0, 1'b0,1'b0,1'b0, 5'd7, 1'b1, 32'd3, 32'd1};
        // freeze holds illegal slot
        vecs[12] = '{1'b1,1'b1,1'b0,1'b1, 32'h0000_0300, 32'h0000_0077, 32'h0000_0088, 32'h0000_0099, 4'h2, 1'b0,1'b0,1'b1, 5'd9,
                     1'b1, 32'h118, 32'h4, 32'h5, 32'h6, 4'h0, 1'b0,1'b0,1'b0, 5'd7, 1'b1, 32'd4, 32'd1};
        // reset while frozen
        vecs[13] = '{1'b0,1'b1,1'b0,1'b1, 32'h0000_0304, 32'h0000_0078, 32'h0000_0089, 32'h0000_009A, 4'h2, 1'b0,1'b0,1'b1, 5'd9,
                     1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0,1'b0,1'b0, 5'd0, 1'b0, 32'd0, 32'd0};
        // resume: SRA load
        vecs[14] = '{1'b1,1'b0,1'b0,1'b1, 32'h0000_0120, 32'hDEAD_BEEF, 32'h0000_000F, 32'h0000_CAFE, 4'h9, 1'b0,1'b0,1'b1, 5'd10,
                     1'b1, 32'h120, 32'hDEAD_BEEF, 32'hF, 32'hCAFE, 4'h9, 1'b0,1'b0,1'b1, 5'd10, 1'b0, 32'd0, 32'd0};
        // flush alone
        vecs[15] = '{1'b1,1'b0,1'b1,1'b1, 32'h0000_0400, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'h4, 1'b1,1'b0,1'b1, 5'd6,
                     1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0,1'b0,1'b0, 5'd0, 1'b0, 32'd0, 32'd1};
        // SRL (highest legal code)
        vecs[16] = '{1'b1,1'b0,1'b0,1'b1, 32'h0000_0124, 32'h8000_0000, 32'h0000_0004, 32'h0000_0000, 4'hA, 1'b0,1'b0,1'b1, 5'd1,
                     1'b1, 32'h124, 32'h8000_0000, 32'h4, 32'h0, 4'hA, 1'b0,1'b0,1'b1, 5'd1, 1'b0, 32'd0, 32'd1};
        // cmd 1111 with load -> illegal
        vecs[17] = '{1'b1,1'b0,1'b0,1'b1, 32'h0000_0128, 32'h0000_0001, 32'h0000_0001, 32'h0000_0099, 4'hF, 1'b1,1'b0,1'b1, 5'd9,
                     1'b1, 32'h128, 32'h1, 32'h1, 32'h99, 4'h0, 1'b0,1'b0,1'b0, 5'd9, 1'b1, 32'd0, 32'd1};
        // reset beats flush, no bubble counted
        vecs[18] = '{1'b0,1'b0,1'b1,1'b1, 32'h0000_0500, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004, 4'h0, 1'b0,1'b0,1'b1, 5'd5,
                     1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0,1'b0,1'b0, 5'd0, 1'b0, 32'd0, 32'd0};
        // OR store after reset
        vecs[19] = '{1'b1,1'b0,1'b0,1'b1, 32'h0000_012C, 32'h0000_0F0F, 32'h0000_F0F0, 32'h0000_0077, 4'h5, 1'b0,1'b1,1'b0, 5'd0,
                     1'b1, 32'h12C, 32'hF0F, 32'hF0F0, 32'h77, 4'h5, 1'b0,1'b1,1'b0, 5'd0, 1'b0, 32'd0, 32'd0};

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check(i, vecs[i]);
        end

        // Illegal slot stays flagged across a two-cycle stall, then a legal load clears it.
        begin
            vec_t s;
            s = vecs[17];
            drive(s);
            @(posedge clk); #1;
            chk("ill_capture", 100, 32'(ex_illegal), 32'd1);
            freeze = 1'b1; id_exe_cmd = 4'h2; id_pc = 32'h0000_0600;
            for (int k = 0; k < 2; k++) begin
                @(posedge clk); #1;
                chk("ill_hold",    101 + k, 32'(ex_illegal), 32'd1);
                chk("pc_hold",     101 + k, ex_pc,           32'h0000_0128);
                chk("valid_hold",  101 + k, 32'(ex_valid),   32'd1);
            end
`ifdef ID_EXE_PERF_EN
            chk("stall_count", 103, perf_stalls, 32'd2);
`else
            chk("stall_count", 103, perf_stalls, 32'd0);
`endif
            freeze = 1'b0; id_valid = 1'b1; id_mem_r_en = 1'b0; id_wb_en = 1'b1;
            @(posedge clk); #1;
            chk("ill_clear", 104, 32'(ex_illegal), 32'd0);
            chk("cmd_after", 104, 32'(ex_exe_cmd), 32'd2);
            chk("pc_after",  104, ex_pc,           32'h0000_0600);
            chk("wb_after",  104, 32'(ex_wb_en),   32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
